// File: rtl/rr_mux_ctrl_if.sv
// Bundle between the round-robin controller, the two requesting sources
// and the downstream 2:1 multiplexer whose output it captures.
interface rr_mux_ctrl_if #(
  parameter int N = 1
);
  logic         req0;
  logic         req1;
  logic [N-1:0] mux_out;
  logic         sel;
  logic         grant0;
  logic         grant1;
  logic [N-1:0] out;
  logic         out_valid;
  logic [3:0]   count;

  modport master (
    output req0, req1, mux_out,
    input  sel, grant0, grant1, out, out_valid, count
  );

  modport slave (
    input  req0, req1, mux_out,
    output sel, grant0, grant1, out, out_valid, count
  );
endinterface

// File: rtl/rr_mux_ctrl.sv
// Two-source round-robin grant FSM with bounded bursts; drives the mux select
// and registers the multiplexer output during every granted cycle.
module rr_mux_ctrl #(
  parameter int N     = 1,
  parameter int BURST = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rr_mux_ctrl_if.slave mux_if
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GNT0   = 2'd1;
  localparam logic [1:0] S_GNT1   = 2'd2;
  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  logic [1:0]   state_q, state_d;
  logic [3:0]   count_q, count_d;
  logic         last_q, last_d;
  logic [N-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;

  logic         in_grant;
  logic         owner;
  logic         own_req;
  logic         other_req;
  logic         grant_end;

  // Arbitration from IDLE: a tie goes to the source that was not served last.
  function automatic logic [1:0] pick_from_idle(input logic r0, input logic r1,
                                                input logic last);
    logic [1:0] nxt;
    nxt = S_IDLE;
    if (r0 && r1)
      nxt = last ? S_GNT0 : S_GNT1;
    else if (r0)
      nxt = S_GNT0;
    else if (r1)
      nxt = S_GNT1;
    return nxt;
  endfunction

  function automatic logic [1:0] gnt_state(input logic src);
    return src ? S_GNT1 : S_GNT0;
  endfunction

  assign in_grant  = (state_q == S_GNT0) || (state_q == S_GNT1);
  assign owner     = (state_q == S_GNT1);
  assign own_req   = owner ? mux_if.req1 : mux_if.req0;
  assign other_req = owner ? mux_if.req0 : mux_if.req1;
  assign grant_end = !own_req || (count_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        count_d = 4'd0;
        state_d = pick_from_idle(mux_if.req0, mux_if.req1, last_q);
      end
      S_GNT0, S_GNT1: begin
        if (grant_end) begin
          last_d  = owner;
          count_d = 4'd0;
          if (other_req)
            state_d = gnt_state(!owner);
          else if (own_req)
            state_d = gnt_state(owner);
          else
            state_d = S_IDLE;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    out_d       = in_grant ? mux_if.mux_out : out_q;
    out_valid_d = in_grant;
  end

  // State register: reset restarts arbitration as if from power-up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      count_q     <= 4'd0;
      last_q      <= 1'b1;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mux_if.grant0    = (state_q == S_GNT0);
  assign mux_if.grant1    = (state_q == S_GNT1);
  assign mux_if.sel       = (state_q == S_GNT1);
  assign mux_if.count     = count_q;
  assign mux_if.out       = out_q;
  assign mux_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_ctrl.sv
// Bench for rr_mux_ctrl: a BURST=4/N=4 and a BURST=1/N=1 instance share
// stimulus and are compared against an owner/run-length reference model.
module tb_rr_mux_ctrl;

  localparam int BA = 4;
  localparam int BB = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [3:0] mo = 4'd0;

  int total = 0;
  int bad   = 0;

  rr_mux_ctrl_if #(.N(4)) ifa ();
  rr_mux_ctrl_if #(.N(1)) ifb ();

  assign ifa.req0    = req0;
  assign ifa.req1    = req1;
  assign ifa.mux_out = mo;
  assign ifb.req0    = req0;
  assign ifb.req1    = req1;
  assign ifb.mux_out = mo[0];

  rr_mux_ctrl #(.N(4), .BURST(BA)) dut_a (.clk_i(clk), .rst_i(rst), .mux_if(ifa));
  rr_mux_ctrl #(.N(1), .BURST(BB)) dut_b (.clk_i(clk), .rst_i(rst), .mux_if(ifb));

  always #5 clk = ~clk;

  // Reference model: who owns the path (-1 none), cycles used in the run,
  // who was served last, and the captured data.
  int         m_owner[2];
  int         m_cnt[2];
  int         m_last[2];
  logic [3:0] m_out[2];
  logic       m_vld[2];

  function automatic logic rq(int i);
    return (i == 0) ? req0 : req1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_cnt[k]   = 0;
      m_last[k]  = 1;
      m_out[k]   = 4'd0;
      m_vld[k]   = 1'b0;
    end
  endtask

  task automatic model_edge(int k, int burst);
    int x;
    if (m_owner[k] < 0) begin
      m_vld[k] = 1'b0;
      m_cnt[k] = 0;
      if (req0 && req1) m_owner[k] = 1 - m_last[k];
      else if (req0)    m_owner[k] = 0;
      else if (req1)    m_owner[k] = 1;
    end else begin
      x        = m_owner[k];
      m_vld[k] = 1'b1;
      m_out[k] = (k == 0) ? mo : {3'b000, mo[0]};
      if (!rq(x) || m_cnt[k] == burst - 1) begin
        m_last[k] = x;
        m_cnt[k]  = 0;
        if (rq(1 - x))  m_owner[k] = 1 - x;
        else if (rq(x)) m_owner[k] = x;
        else            m_owner[k] = -1;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  function automatic logic [11:0] exp_v(int k);
    return {m_owner[k] == 0, m_owner[k] == 1, m_owner[k] == 1,
            4'(m_cnt[k]), m_vld[k], m_out[k]};
  endfunction

  function automatic logic [11:0] act_a();
    return {ifa.grant0, ifa.grant1, ifa.sel, ifa.count, ifa.out_valid, ifa.out};
  endfunction

  function automatic logic [11:0] act_b();
    return {ifb.grant0, ifb.grant1, ifb.sel, ifb.count, ifb.out_valid, 3'b000, ifb.out};
  endfunction

  // Advance one clock; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_edge(0, BA);
      model_edge(1, BB);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (act_a() !== 12'h000) begin
      bad++;
      $display("FAIL reset_a actual=%h required=%h", act_a(), 12'h000);
    end
    total++;
    if (act_b() !== 12'h000) begin
      bad++;
      $display("FAIL reset_b actual=%h required=%h", act_b(), 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dual_burst();
    logic g0_exp;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      mo = 4'($urandom);
      tick();
      g0_exp = (((i - 1) / BA) % 2) == 0;
      total++;
      if (ifa.grant0 !== g0_exp || ifa.sel !== !g0_exp || ifa.count !== 4'((i - 1) % BA)) begin
        bad++;
        $display("FAIL dual_seq cyc=%0d actual g0=%b sel=%b cnt=%0d required g0=%b sel=%b cnt=%0d",
                 i, ifa.grant0, ifa.sel, ifa.count, g0_exp, !g0_exp, (i - 1) % BA);
      end
      total++;
      if (ifb.grant0 !== (i % 2 == 1) || ifb.grant1 !== (i % 2 == 0) || ifb.count !== 4'd0) begin
        bad++;
        $display("FAIL burst1_alt cyc=%0d actual g0=%b g1=%b cnt=%0d required g0=%b g1=%b cnt=0",
                 i, ifb.grant0, ifb.grant1, ifb.count, i % 2 == 1, i % 2 == 0);
      end
      total++;
      if (act_a() !== exp_v(0)) begin
        bad++;
        $display("FAIL dual_model cyc=%0d actual=%h required=%h", i, act_a(), exp_v(0));
      end
    end
  endtask

  task automatic test_single_req0();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      mo = 4'($urandom);
      tick();
      total++;
      if (ifa.grant0 !== 1'b1 || ifa.count !== 4'((i - 1) % BA) || ifa.out_valid !== (i >= 2)) begin
        bad++;
        $display("FAIL single_req0 cyc=%0d actual g0=%b cnt=%0d vld=%b required g0=1 cnt=%0d vld=%b",
                 i, ifa.grant0, ifa.count, ifa.out_valid, (i - 1) % BA, i >= 2);
      end
      total++;
      if (act_b() !== exp_v(1)) begin
        bad++;
        $display("FAIL single_req0_b cyc=%0d actual=%h required=%h", i, act_b(), exp_v(1));
      end
    end
  endtask

  task automatic test_drop_capture();
    do_reset();
    req0 = 1'b0;
    req1 = 1'b1;
    mo   = 4'hB;
    tick();
    total++;
    if (ifb.grant1 !== 1'b1 || ifb.sel !== 1'b1 || ifb.count !== 4'd0) begin
      bad++;
      $display("FAIL req1_first actual g1=%b sel=%b cnt=%0d required g1=1 sel=1 cnt=0",
               ifb.grant1, ifb.sel, ifb.count);
    end
    mo = 4'h5;
    tick();
    total++;
    if (ifa.grant1 !== 1'b1 || ifa.count !== 4'd1) begin
      bad++;
      $display("FAIL req1_second actual g1=%b cnt=%0d required g1=1 cnt=1", ifa.grant1, ifa.count);
    end
    req1 = 1'b0;
    mo   = 4'hD;
    tick();
    total++;
    if (ifa.grant1 !== 1'b0 || ifa.sel !== 1'b0 || ifa.out !== 4'hD || ifa.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_capture actual g1=%b sel=%b out=%h vld=%b required g1=0 sel=0 out=d vld=1",
               ifa.grant1, ifa.sel, ifa.out, ifa.out_valid);
    end
    total++;
    if (ifb.out !== 1'b1 || ifb.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_capture_b actual out=%b vld=%b required out=1 vld=1", ifb.out, ifb.out_valid);
    end
    mo = 4'h0;
    tick();
    total++;
    if (ifa.out_valid !== 1'b0 || ifa.out !== 4'hD || ifb.out !== 1'b1 || ifb.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold actual a.out=%h a.vld=%b b.out=%b b.vld=%b required d 0 1 0",
               ifa.out, ifa.out_valid, ifb.out, ifb.out_valid);
    end
    total++;
    if (act_a() !== exp_v(0)) begin
      bad++;
      $display("FAIL idle_model actual=%h required=%h", act_a(), exp_v(0));
    end
  endtask

  task automatic test_async_reset_mid();
    do_reset();
    req0 = 1'b0;
    req1 = 1'b1;
    mo   = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (ifa.grant1 !== 1'b1 || ifa.count !== 4'd2) begin
      bad++;
      $display("FAIL pre_reset actual g1=%b cnt=%0d required g1=1 cnt=2", ifa.grant1, ifa.count);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (act_a() !== 12'h000 || act_b() !== 12'h000) begin
      bad++;
      $display("FAIL async_reset actual a=%h b=%h required 000 000", act_a(), act_b());
    end
    req0 = 1'b1;
    req1 = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    total++;
    if (ifa.grant0 !== 1'b1 || ifa.grant1 !== 1'b0 || ifb.grant0 !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_tie actual a.g0=%b a.g1=%b b.g0=%b required 1 0 1",
               ifa.grant0, ifa.grant1, ifb.grant0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) req1 = $urandom_range(0, 1) == 1;
      mo = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
      end
      tick();
      total++;
      if (act_a() !== exp_v(0)) begin
        bad++;
        $display("FAIL random_a cyc=%0d actual=%h required=%h", i, act_a(), exp_v(0));
      end
      total++;
      if (act_b() !== exp_v(1)) begin
        bad++;
        $display("FAIL random_b cyc=%0d actual=%h required=%h", i, act_b(), exp_v(1));
      end
      total++;
      if ((ifa.grant0 && ifa.grant1) !== 1'b0 || (ifb.grant0 && ifb.grant1) !== 1'b0) begin
        bad++;
        $display("FAIL grant_overlap cyc=%0d actual a=%b%b b=%b%b required no overlap",
                 i, ifa.grant0, ifa.grant1, ifb.grant0, ifb.grant1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dual_burst();
    test_single_req0();
    test_drop_capture();
    test_async_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_ctrl.md
RR_MUX_CTRL -- requirements
Module: rr_mux_ctrl

Interface
REQ-001 Parameter N, default 1: data width of the two-source path; matches the multiplexer N.
REQ-002 Parameter BURST, default 4: maximum consecutive cycles per grant; legal range 1..15.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  source 0 requests the path.
REQ-006 req1  input  1  source 1 requests the path.
REQ-007 mux_out  input  N  output of the downstream 2:1 multiplexer (in0 when sel=0, in1 when sel=1).
REQ-008 sel  output  1  select driven into the multiplexer select input.
REQ-009 grant0  output  1  source 0 owns the path this cycle.
REQ-010 grant1  output  1  source 1 owns the path this cycle.
REQ-011 out  output  N  registered capture of mux_out.
REQ-012 out_valid  output  1  out holds data captured during a grant.
REQ-013 count  output  4  cycles elapsed in the current burst (0..BURST-1).

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, GNT0, GNT1 plus a 4-bit burst counter and a 1-bit last-served pointer.
REQ-015 Outputs SHALL decode from registered state only: grant0=(GNT0), grant1=(GNT1), sel=(GNT1); sel=0 in IDLE and GNT0.
REQ-016 From IDLE, if req0 and req1 are both high, the SHALL enter the state of the source not equal to last; if only one is high, enter that source's state; if none, remain IDLE.
REQ-017 Entering any GNT state SHALL load count=0; each further cycle in the same grant SHALL increment count by 1.
REQ-018 In GNTx the grant SHALL end at the edge where reqx=0 or count=BURST-1.
REQ-019 On grant end: other source requesting -> enter its GNT state; else reqx still high -> re-enter GNTx with count=0 (no idle gap); else -> IDLE.
REQ-020 On every grant end, last SHALL update to x.
REQ-021 With BURST=1, each grant SHALL last exactly one cycle and alternate on continuous dual requests.
REQ-022 At every edge in GNT0/GNT1, out SHALL load mux_out and out_valid SHALL become 1 (latency one cycle from the grant cycle).
REQ-023 At every edge in IDLE, out_valid SHALL become 0 and out SHALL hold its value.
REQ-024 A request dropping mid-burst SHALL take effect at the next edge; the cycle when the drop is sampled is still a granted cycle.
REQ-025 grant0 and grant1 SHALL never be high simultaneously.

Reset
REQ-026 reset=1 SHALL immediately, without a clock edge, force state=IDLE, count=0, last=1, out=0, out_valid=0, sel=0, grant0=0, grant1=0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration restarts as from power-up (source 0 wins a tie).
REQ-028 Requests SHALL be sampled starting with the first rising edge after reset deasserts.

Verification
REQ-029 BURST=4, req0=req1=1 held from reset release -> grant0 cycles 1-4 (count 0,1,2,3), grant1 cycles 5-8, grant0 cycles 9-12; sel 0,0,0,0,1,1,1,1,0.
REQ-030 BURST=4, only req0=1 held -> grant0 continuously high, count 0,1,2,3,0,1..., out_valid stays 1 after the first grant cycle.
REQ-031 N=1, GNT1 with mux_out=1, then request dropped -> out=1 and out_valid=1 one cycle later; next IDLE edge -> out_valid=0, out remains 1.
REQ-032 req1 alone, deasserted while count=1 -> grant1 high for 2 cycles, then IDLE, sel returns to 0.
REQ-033 reset pulsed between edges during GNT1 at count=2 -> all outputs 0 immediately; after release with both requests, grant0 wins first.
REQ-034 BURST=1, both requests held -> grant0 and grant1 alternate every cycle, count always 0, grants never overlap.
